// File: rtl/clefia_rk_reader.sv
// clefia_rk_reader
// Round-key buffer and reader for the CLEFIA-128 datapath.
// Keys are written serially, in index order, while idle. Once all NRK
// words are present the block streams them one round (key pair) per
// valid/ready transfer. The order is forward for encryption and reverse
// for decryption. Keys stay in place after a stream, so the next block
// can start again without a reload.
//
// Optional feature macro: CLEFIA_RK_PARITY_EN
//   defined   : every stored word keeps an even-parity bit. o_out_perr
//               flags a pair in which either word fails its check.
//   undefined : no parity storage, and o_out_perr is tied 0.
//
// Ports
//   i_clk        clock, all logic on posedge
//   i_rst_n      synchronous reset, active low
//   i_clear      synchronous flush back to IDLE (same effect as reset)
//   i_in_wr      write strobe, one key per cycle (IDLE only)
//   i_in_rk      32-bit round key word
//   i_start      begin streaming (LOADED only)
//   i_dec        sampled with i_start: 0 forward, 1 reverse
//   o_out_valid  a round pair is presented
//   i_out_ready  consumer accepts the pair when valid & ready
//   o_out_rk0    first key of the pair
//   o_out_rk1    second key of the pair
//   o_out_round  round number in stream order
//   o_loaded     high in LOADED
//   o_done       one-cycle pulse after the final transfer
//   o_out_perr   parity error on the presented pair
module clefia_rk_reader #(
    parameter int NRK = 36,
    parameter int AW  = 6,
    parameter int RW  = 5
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_in_wr,
    input  logic [31:0]   i_in_rk,
    input  logic          i_start,
    input  logic          i_dec,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [31:0]   o_out_rk0,
    output logic [31:0]   o_out_rk1,
    output logic [RW-1:0] o_out_round,
    output logic          o_loaded,
    output logic          o_done,
    output logic          o_out_perr
);

    localparam int NR = NRK / 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOADED = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic [31:0]   r_mem [NRK];
    logic [AW-1:0] r_wr_ptr;
    logic [RW-1:0] r_round;
    logic          r_dec;
    logic          r_out_valid;
    logic [31:0]   r_out_rk0;
    logic [31:0]   r_out_rk1;
    logic          r_loaded;
    logic          r_done;
    logic          r_out_perr;

    logic          w_wr_en;
    logic          w_launch;
    logic          w_xfer;
    logic          w_last_xfer;
    logic          w_last_round;
    logic          w_dec_eff;
    logic [RW-1:0] w_nr;
    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_idx1;
    logic          w_perr;

    assign w_last_round = (r_round == RW'(NR - 1));

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // Next state and control strobes. A clear overrides everything, so any
    // write or start in the same cycle is dropped.
    always_comb begin
        w_next_state = r_state;
        w_wr_en      = 1'b0;
        w_launch     = 1'b0;
        w_xfer       = 1'b0;
        w_last_xfer  = 1'b0;
        if (i_clear) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_wr) begin
                        w_wr_en = 1'b1;
                        if (r_wr_ptr == AW'(NRK - 1)) w_next_state = S_LOADED;
                    end
                end
                S_LOADED: begin
                    if (i_start) begin
                        w_launch     = 1'b1;
                        w_next_state = S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (r_out_valid && i_out_ready) begin
                        w_xfer = 1'b1;
                        if (w_last_round) begin
                            w_last_xfer  = 1'b1;
                            w_next_state = S_LOADED;
                        end
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Next round to present. On launch it is round 0, and i_dec is used
    // directly because r_dec is only captured on this same edge.
    always_comb begin
        w_dec_eff = w_launch ? i_dec : r_dec;
        w_nr      = w_launch ? '0 : r_round + RW'(1);
        if (w_dec_eff) w_idx = AW'(NRK - 2) - AW'({w_nr, 1'b0});
        else           w_idx = AW'({w_nr, 1'b0});
        w_idx1 = w_idx + AW'(1);
    end

    // Key storage. The contents are not reset: after a reset or clear they
    // cannot be read until a full reload has overwritten them.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= i_in_rk;
    end

`ifdef CLEFIA_RK_PARITY_EN
    logic r_par [NRK];

    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_par[r_wr_ptr] <= ^i_in_rk;
    end

    assign w_perr = ((^r_mem[w_idx])  ^ r_par[w_idx]) |
                    ((^r_mem[w_idx1]) ^ r_par[w_idx1]);
`else
    assign w_perr = 1'b0;
`endif

    // Write pointer. It stops at NRK-1, so it never wraps even when NRK
    // fills the whole AW range.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_wr_ptr <= '0;
        end else if (w_wr_en && (r_wr_ptr != AW'(NRK - 1))) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
        end
    end

    // Registered output stage. A pair is loaded on launch and on every
    // transfer except the last one, so transfers can run back to back.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_round     <= '0;
            r_dec       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_rk0   <= '0;
            r_out_rk1   <= '0;
            r_loaded    <= 1'b0;
            r_done      <= 1'b0;
            r_out_perr  <= 1'b0;
        end else begin
            r_loaded <= (w_next_state == S_LOADED);
            r_done   <= w_last_xfer;
            if (w_launch) r_dec <= i_dec;
            if (w_launch || (w_xfer && !w_last_round)) begin
                r_out_valid <= 1'b1;
                r_round     <= w_nr;
                r_out_rk0   <= r_mem[w_idx];
                r_out_rk1   <= r_mem[w_idx1];
                r_out_perr  <= w_perr;
            end else if (w_last_xfer) begin
                r_out_valid <= 1'b0;
                r_round     <= '0;
                r_out_perr  <= 1'b0;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_rk0   = r_out_rk0;
    assign o_out_rk1   = r_out_rk1;
    assign o_out_round = r_round;
    assign o_loaded    = r_loaded;
    assign o_done      = r_done;
    assign o_out_perr  = r_out_perr;

endmodule

// File: tb/tb_clefia_rk_reader.sv
module tb_clefia_rk_reader;

    localparam int NRK = 36;
    localparam int NR  = NRK / 2;

    logic        clk = 1'b0;
    logic        rst_n, clear, in_wr, start, dec, out_ready;
    logic [31:0] in_rk;
    logic        out_valid, loaded, done, out_perr;
    logic [31:0] out_rk0, out_rk1;
    logic [4:0]  out_round;

    int vectors = 0;
    int miscompares = 0;

    // Reference contents of the key store, as written by the bench
    logic [31:0] mem_m [NRK];
    int          flip_idx = -1;

    always #5 clk = ~clk;

    clefia_rk_reader dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_in_wr(in_wr),
        .i_in_rk(in_rk), .i_start(start), .i_dec(dec),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_rk0(out_rk0), .o_out_rk1(out_rk1), .o_out_round(out_round),
        .o_loaded(loaded), .o_done(done), .o_out_perr(out_perr)
    );

    function automatic int pair_idx(input bit d, input int r);
        return d ? (NRK - 2 - 2 * r) : (2 * r);
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; clear = 1'b0; in_wr = 1'b0; in_rk = '0;
        start = 1'b0; dec = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({out_valid, loaded, done, out_perr} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_flags got v=%b l=%b d=%b p=%b want 0000",
                     out_valid, loaded, done, out_perr);
        end
        vectors++;
        if ({out_rk0, out_rk1, out_round} !== 69'b0) begin
            miscompares++;
            $display("FAIL reset_data got %h %h %0d want 0 0 0", out_rk0, out_rk1, out_round);
        end
    endtask

    // Writes NRK words. A start pulse in the middle must be ignored while
    // the block is in IDLE.
    task automatic test_load(input bit random_keys);
        for (int i = 0; i < NRK; i++) begin
            @(negedge clk);
            vectors++;
            if (loaded !== 1'b0 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL load_early idx=%0d got loaded=%b valid=%b want 0 0", i, loaded, out_valid);
            end
            mem_m[i] = random_keys ? $urandom : (32'h0000_0100 + 32'(i));
            in_wr = 1'b1;
            in_rk = mem_m[i];
            start = (i == 10);
        end
        @(negedge clk);
        in_wr = 1'b0; start = 1'b0;
        vectors++;
        if (loaded !== 1'b1) begin
            miscompares++;
            $display("FAIL load_done got loaded=%b want 1", loaded);
        end
    endtask

    // Writes issued in LOADED must not modify the stored keys.
    task automatic test_extra_writes;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_wr = 1'b1;
            in_rk = $urandom;
        end
        @(negedge clk);
        in_wr = 1'b0;
        vectors++;
        if (loaded !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL extra_wr got loaded=%b valid=%b want 1 0", loaded, out_valid);
        end
    endtask

    // mode 0: always ready; 1: random ready; 2: 3-cycle stall at round 5.
    // Every valid cycle is checked against the beat expected next, so a
    // held beat is checked for stability and a skipped one is caught.
    task automatic run_stream(input bit d, input int mode, input string tag);
        int  got = 0, cyc = 0, stalls = 0, r5_cycles = 0;
        bit  rdy;
        int  ix;
        bit  exp_perr;
        @(negedge clk);
        start = 1'b1; dec = d; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; dec = $urandom_range(0, 1);
        while (got < NR && cyc < 400) begin
            ix = pair_idx(d, got);
            exp_perr = (flip_idx == ix) || (flip_idx == ix + 1);
            vectors++;
            if (out_valid !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL %s_valid beat=%0d got v=%b d=%b want 1 0", tag, got, out_valid, done);
            end else if (out_rk0 !== mem_m[ix] || out_rk1 !== mem_m[ix + 1] ||
                         out_round !== 5'(got) || out_perr !== exp_perr) begin
                miscompares++;
                $display("FAIL %s_beat got %h %h r%0d p%b want %h %h r%0d p%b", tag,
                         out_rk0, out_rk1, out_round, out_perr,
                         mem_m[ix], mem_m[ix + 1], got, exp_perr);
            end
            if (got == 5) r5_cycles++;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: begin
                    rdy = !(got == 5 && stalls < 3);
                    if (!rdy) stalls++;
                end
            endcase
            out_ready = rdy;
            if (out_valid && rdy) got++;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        vectors++;
        if (cyc >= 400) begin
            miscompares++;
            $display("FAIL %s_timeout got %0d beats want %0d", tag, got, NR);
        end
        if (mode == 2) begin
            vectors++;
            if (r5_cycles != 4) begin
                miscompares++;
                $display("FAIL %s_hold got %0d cycles at round 5 want 4", tag, r5_cycles);
            end
        end
        vectors++;
        if (done !== 1'b1 || out_valid !== 1'b0 || loaded !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_end got d=%b v=%b l=%b want 1 0 1", tag, done, out_valid, loaded);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || loaded !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_pulse got d=%b l=%b want 0 1", tag, done, loaded);
        end
    endtask

    // clear together with start at round 9 abandons the stream with no done
    task automatic test_clear_mid_stream;
        int cyc = 0;
        @(negedge clk);
        start = 1'b1; dec = 1'b0;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b1;
        while (!(out_valid === 1'b1 && out_round === 5'd9) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (cyc >= 100) begin
            miscompares++;
            $display("FAIL clr_reach got round=%0d want 9", out_round);
        end
        clear = 1'b1; start = 1'b1;
        @(negedge clk);
        clear = 1'b0; start = 1'b0; out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || loaded !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_state got v=%b l=%b d=%b want 0 0 0", out_valid, loaded, done);
        end
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL clr_after got v=%b d=%b want 0 0", out_valid, done);
            end
        end
        start = 1'b0;
    endtask

    // clear and start together in LOADED: no stream, back to IDLE
    task automatic test_clear_with_start;
        @(negedge clk);
        clear = 1'b1; start = 1'b1;
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || loaded !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_start got v=%b l=%b want 0 0", out_valid, loaded);
        end
    endtask

    initial begin
        test_reset();
        test_load(1'b0);
        run_stream(1'b0, 0, "fwd");
        run_stream(1'b1, 0, "rev");
        run_stream(1'b0, 2, "bp");
        test_extra_writes();
        run_stream(1'b1, 1, "rnd_rev");
        test_clear_mid_stream();
        test_load(1'b1);
        run_stream(1'b0, 1, "reload_fwd");
        run_stream(1'b1, 1, "reload_rev");
`ifdef CLEFIA_RK_PARITY_EN
        dut.r_mem[7] = dut.r_mem[7] ^ 32'h0000_0010;
        mem_m[7] = mem_m[7] ^ 32'h0000_0010;
        flip_idx = 7;
        run_stream(1'b0, 0, "perr");
        flip_idx = -1;
`endif
        test_clear_with_start();
        test_load(1'b1);
        run_stream(1'b1, 0, "final_rev");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
